// File: rtl/lru_set_replacer.sv
// lru_set_replacer: multi-set true-LRU age tracker with registered victim selection
// Ports: clk/rst_n (async active-low); acc_* hit/fill updates (way -> MRU);
// inv_* coherence invalidations (way -> LRU); vq_* victim query, answered next
// cycle on victim_valid/victim_way/victim_none; onehot_err flags malformed ways.
// Build option: define LRU_WAY_LOCK_EN to let vq_lock exclude ways from victim choice.
module lru_set_replacer #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  localparam int AGE_W = $clog2(NUM_WAYS),
  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                acc_valid,
  input  logic [SET_W-1:0]    acc_set,
  input  logic [NUM_WAYS-1:0] acc_way,
  input  logic                inv_valid,
  input  logic [SET_W-1:0]    inv_set,
  input  logic [NUM_WAYS-1:0] inv_way,
  input  logic                vq_valid,
  input  logic [SET_W-1:0]    vq_set,
  input  logic [NUM_WAYS-1:0] vq_line_valid,
  input  logic [NUM_WAYS-1:0] vq_lock,
  output logic                victim_valid,
  output logic [AGE_W-1:0]    victim_way,
  output logic                victim_none,
  output logic                onehot_err
);
  // Masking keeps a 1-set build from indexing past its single entry.
  localparam logic [SET_W-1:0] SET_MASK = SET_W'(NUM_SETS - 1);
  logic [AGE_W-1:0]    age_q [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0]    age_d [NUM_SETS][NUM_WAYS];
  logic                victim_valid_q, victim_valid_d;
  logic [AGE_W-1:0]    victim_way_q, victim_way_d;
  logic                victim_none_q, victim_none_d;
  logic                onehot_err_q, onehot_err_d;
  logic                acc_ok, inv_ok, acc_go, inv_go;
  logic [SET_W-1:0]    acc_s, inv_s, vq_s;
  logic [AGE_W-1:0]    acc_i, inv_i, acc_a, inv_a;
  logic [NUM_WAYS-1:0] elig, cand;
  logic [AGE_W-1:0]    lo_way, old_way, best;
`ifdef LRU_WAY_LOCK_EN
  assign elig = ~vq_lock;
`else
  logic unused_lock;
  assign unused_lock = ^vq_lock;
  assign elig = '1;
`endif
  always_comb begin
    acc_ok = (acc_way != '0) && ((acc_way & (acc_way - NUM_WAYS'(1))) == '0);
    inv_ok = (inv_way != '0) && ((inv_way & (inv_way - NUM_WAYS'(1))) == '0);
    acc_s = acc_set & SET_MASK;
    inv_s = inv_set & SET_MASK;
    vq_s = vq_set & SET_MASK;
    acc_i = '0;
    inv_i = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      acc_i = acc_way[w] ? AGE_W'(w) : acc_i;
      inv_i = inv_way[w] ? AGE_W'(w) : inv_i;
    end
    acc_a = age_q[acc_s][acc_i];
    inv_a = age_q[inv_s][inv_i];
    acc_go = acc_valid && acc_ok;
    // An access wins over an invalidation of the same set in the same cycle.
    inv_go = inv_valid && inv_ok && !(acc_go && acc_s == inv_s);
    age_d = age_q;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (acc_go)
        age_d[acc_s][w] = acc_way[w] ? '0 :
                          (age_q[acc_s][w] < acc_a) ? age_q[acc_s][w] + 1'b1 : age_q[acc_s][w];
      if (inv_go)
        age_d[inv_s][w] = inv_way[w] ? AGE_W'(NUM_WAYS - 1) :
                          (age_q[inv_s][w] > inv_a) ? age_q[inv_s][w] - 1'b1 : age_q[inv_s][w];
    end
    // Victim choice reads pre-update ages: lowest eligible invalid way, else oldest eligible.
    cand = elig & ~vq_line_valid;
    lo_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      lo_way = cand[w] ? AGE_W'(w) : lo_way;
    old_way = '0;
    best = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (elig[w] && age_q[vq_s][w] >= best) begin
        best = age_q[vq_s][w];
        old_way = AGE_W'(w);
      end
    victim_way_d = (|cand) ? lo_way : old_way;
`ifdef LRU_WAY_LOCK_EN
    victim_none_d = ~|elig;
`else
    victim_none_d = 1'b0;
`endif
    victim_valid_d = vq_valid;
    onehot_err_d = (acc_valid && !acc_ok) || (inv_valid && !inv_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
      victim_valid_q <= 1'b0;
      victim_way_q <= '0;
      victim_none_q <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      age_q <= age_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q <= victim_way_d;
      victim_none_q <= victim_none_d;
      onehot_err_q <= onehot_err_d;
    end
  end
  assign victim_valid = victim_valid_q;
  assign victim_way = victim_way_q;
  assign victim_none = victim_none_q;
  assign onehot_err = onehot_err_q;
endmodule

// File: tb/tb_lru_set_replacer.sv
// tb_lru_set_replacer: directed self-checking bench for lru_set_replacer (4 ways, 64 sets)
module tb_lru_set_replacer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       acc_valid, inv_valid, vq_valid;
  logic [5:0] acc_set, inv_set, vq_set;
  logic [3:0] acc_way, inv_way, vq_line_valid, vq_lock;
  logic       victim_valid, victim_none, onehot_err;
  logic [1:0] victim_way;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  lru_set_replacer #(.NUM_WAYS(4), .NUM_SETS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
    .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
    .vq_valid(vq_valid), .vq_set(vq_set), .vq_line_valid(vq_line_valid), .vq_lock(vq_lock),
    .victim_valid(victim_valid), .victim_way(victim_way),
    .victim_none(victim_none), .onehot_err(onehot_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_acc(input logic [5:0] s, input logic [3:0] w);
    acc_valid = 1'b1; acc_set = s; acc_way = w;
    cycle();
    acc_valid = 1'b0;
  endtask
  task automatic do_inv(input logic [5:0] s, input logic [3:0] w);
    inv_valid = 1'b1; inv_set = s; inv_way = w;
    cycle();
    inv_valid = 1'b0;
  endtask
  task automatic query(input string tag, input logic [5:0] s, input logic [3:0] lv,
                       input logic [3:0] lk, input int exp_way, input int exp_none);
    vq_valid = 1'b1; vq_set = s; vq_line_valid = lv; vq_lock = lk;
    cycle();
    vq_valid = 1'b0;
    check({tag, "_valid"}, victim_valid, 1);
    check({tag, "_way"}, victim_way, exp_way);
    check({tag, "_none"}, victim_none, exp_none);
  endtask
  initial begin
    rst_n = 1'b0;
    {acc_valid, inv_valid, vq_valid} = '0;
    {acc_set, inv_set, vq_set} = '0;
    {acc_way, inv_way, vq_line_valid, vq_lock} = '0;
    repeat (3) cycle();
    check("rst_vv", victim_valid, 0);
    check("rst_way", victim_way, 0);
    check("rst_none", victim_none, 0);
    check("rst_err", onehot_err, 0);
    rst_n = 1'b1;
    cycle();
    query("reset_lru", 0, 4'b1111, 4'b0000, 3, 0);
    cycle();
    check("vv_pulse", victim_valid, 0);
`ifdef LRU_WAY_LOCK_EN
    query("lock_oldest", 0, 4'b1111, 4'b1000, 2, 0);
    query("lock_all", 0, 4'b1111, 4'b1111, 0, 1);
    query("lock_invalid", 0, 4'b0000, 4'b0011, 2, 0);
`else
    query("lock_ignored", 0, 4'b1111, 4'b1000, 3, 0);
`endif
    do_acc(5, 4'b1000); do_acc(5, 4'b0010); do_acc(5, 4'b0001); do_acc(5, 4'b0100);
    query("order_a", 5, 4'b1111, 4'b0000, 3, 0);
    do_acc(5, 4'b1000);
    query("order_b", 5, 4'b1111, 4'b0000, 1, 0);
    query("inv_prio", 5, 4'b1011, 4'b0000, 2, 0);
    do_acc(7, 4'b0001); do_acc(7, 4'b0010); do_acc(7, 4'b0100); do_acc(7, 4'b1000);
    do_inv(7, 4'b1000);
    query("inval_lru", 7, 4'b1111, 4'b0000, 3, 0);
    do_acc(7, 4'b1000);
    query("inval_w0", 7, 4'b1111, 4'b0000, 0, 0);
    do_acc(7, 4'b0001);
    query("inval_w1", 7, 4'b1111, 4'b0000, 1, 0);
    do_acc(7, 4'b0010);
    query("inval_w2", 7, 4'b1111, 4'b0000, 2, 0);
    acc_valid = 1'b1; acc_set = 9; acc_way = 4'b0100;
    inv_valid = 1'b1; inv_set = 9; inv_way = 4'b0100;
    cycle();
    {acc_valid, inv_valid} = '0;
    query("same_set_a", 9, 4'b1111, 4'b0000, 3, 0);
    do_acc(9, 4'b1000);
    query("same_set_b", 9, 4'b1111, 4'b0000, 1, 0);
    acc_valid = 1'b1; acc_set = 11; acc_way = 4'b1000;
    inv_valid = 1'b1; inv_set = 12; inv_way = 4'b0001;
    cycle();
    {acc_valid, inv_valid} = '0;
    query("diff_acc", 11, 4'b1111, 4'b0000, 2, 0);
    query("diff_inv", 12, 4'b1111, 4'b0000, 0, 0);
    do_acc(5, 4'b0110);
    check("err_acc", onehot_err, 1);
    cycle();
    check("err_clear", onehot_err, 0);
    query("bad_acc_ignored", 5, 4'b1111, 4'b0000, 1, 0);
    acc_valid = 1'b1; acc_set = 13; acc_way = 4'b0000;
    inv_valid = 1'b1; inv_set = 13; inv_way = 4'b0001;
    cycle();
    {acc_valid, inv_valid} = '0;
    check("err_zero_acc", onehot_err, 1);
    query("inv_survives", 13, 4'b1111, 4'b0000, 0, 0);
    acc_valid = 1'b1; acc_set = 14; acc_way = 4'b1000;
    inv_valid = 1'b1; inv_set = 14; inv_way = 4'b1100;
    cycle();
    {acc_valid, inv_valid} = '0;
    check("err_inv", onehot_err, 1);
    query("acc_survives", 14, 4'b1111, 4'b0000, 2, 0);
    acc_valid = 1'b1; acc_set = 2; acc_way = 4'b1000;
    query("pre_access", 2, 4'b1111, 4'b0000, 3, 0);
    acc_valid = 1'b0;
    query("post_access", 2, 4'b1111, 4'b0000, 2, 0);
    vq_valid = 1'b1; vq_set = 5; vq_line_valid = 4'b1111; vq_lock = 4'b0000;
    rst_n = 1'b0;
    cycle();
    vq_valid = 1'b0;
    check("rst_drop_vv", victim_valid, 0);
    rst_n = 1'b1;
    cycle();
    query("rst_ages", 5, 4'b1111, 4'b0000, 3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
